// File: rtl/fault_monitor_ctrl.sv
// Multi-channel fault supervisor: round-robin debounce over NCH inputs,
// sticky status latching and one-at-a-time valid/ack event reporting.
module fault_monitor_ctrl #(
    parameter int unsigned NCH        = 4,
    parameter int unsigned CNT_W      = 10,
    parameter int unsigned THRESH_DEF = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [NCH-1:0]           noisy_in,
    input  logic                     cfg_we,
    input  logic [CNT_W-1:0]         cfg_threshold,
    input  logic [NCH-1:0]           clear_mask,
    output logic [NCH-1:0]           fault_status,
    output logic                     alarm,
    output logic                     evt_valid,
    output logic [$clog2(NCH)-1:0]   evt_ch,
    input  logic                     evt_ack,
    output logic [$clog2(NCH)-1:0]   scan_ch
);

    localparam int unsigned CH_W = $clog2(NCH);

    typedef enum logic {S_DISABLED, S_SCAN} scan_state_t;
    typedef enum logic {EV_IDLE, EV_WAIT}   ev_state_t;

    scan_state_t scan_state, scan_state_nxt;
    ev_state_t   ev_state,   ev_state_nxt;

    logic [CNT_W-1:0] cnt [NCH];
    logic [CNT_W-1:0] cnt_nxt [NCH];
    logic [CNT_W-1:0] threshold, threshold_nxt;
    logic [NCH-1:0]   pending, pending_nxt;
    logic [NCH-1:0]   status_nxt;
    logic             alarm_nxt;
    logic             evt_valid_nxt;
    logic [CH_W-1:0]  evt_ch_nxt;
    logic [CH_W-1:0]  scan_ch_nxt;

    logic             visit_c;
    logic             hit_c;
    logic             confirm_c;
    logic [CNT_W-1:0] cur_cnt_c;
    logic [NCH-1:0]   new_fault_c;
    logic [NCH-1:0]   take_mask_c;
    logic [CH_W-1:0]  lowest_c;

    // Lowest-index set bit of the pending vector.
    function automatic logic [CH_W-1:0] lowest_set(input logic [NCH-1:0] v);
        logic [CH_W-1:0] idx;
        idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (v[i]) idx = CH_W'(i);
        end
        return idx;
    endfunction

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_state <= S_DISABLED;
            ev_state   <= EV_IDLE;
        end else begin
            scan_state <= scan_state_nxt;
            ev_state   <= ev_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        scan_state_nxt = scan_state;
        ev_state_nxt   = ev_state;
        case (scan_state)
            S_DISABLED: if (enable)  scan_state_nxt = S_SCAN;
            S_SCAN:     if (!enable) scan_state_nxt = S_DISABLED;
            default:                 scan_state_nxt = S_DISABLED;
        endcase
        case (ev_state)
            EV_IDLE: if (|pending) ev_state_nxt = EV_WAIT;
            EV_WAIT: if (evt_ack)  ev_state_nxt = EV_IDLE;
            default:               ev_state_nxt = EV_IDLE;
        endcase
    end

    // Output / datapath next values; clear always wins over a same-cycle confirm
    always_comb begin
        cnt_nxt       = cnt;
        threshold_nxt = threshold;
        scan_ch_nxt   = scan_ch;
        evt_valid_nxt = evt_valid;
        evt_ch_nxt    = evt_ch;
        new_fault_c   = '0;
        take_mask_c   = '0;

        visit_c   = (scan_state_nxt == S_SCAN);
        hit_c     = noisy_in[scan_ch];
        cur_cnt_c = cnt[scan_ch];
        confirm_c = visit_c && hit_c && (cur_cnt_c == threshold);
        lowest_c  = lowest_set(pending);

        if (scan_state_nxt == S_DISABLED && cfg_we) threshold_nxt = cfg_threshold;

        if (visit_c) begin
            scan_ch_nxt = (scan_ch == CH_W'(NCH - 1)) ? '0 : scan_ch + CH_W'(1);
            if (!hit_c)          cnt_nxt[scan_ch] = '0;
            else if (!confirm_c) cnt_nxt[scan_ch] = cur_cnt_c + CNT_W'(1);
        end
        if (confirm_c && !fault_status[scan_ch]) new_fault_c[scan_ch] = 1'b1;

        case (ev_state)
            EV_IDLE: if (|pending) begin
                evt_valid_nxt         = 1'b1;
                evt_ch_nxt            = lowest_c;
                take_mask_c[lowest_c] = 1'b1;
            end
            EV_WAIT: if (evt_ack) evt_valid_nxt = 1'b0;
            default: evt_valid_nxt = 1'b0;
        endcase

        for (int i = 0; i < NCH; i++) begin
            if (clear_mask[i]) cnt_nxt[i] = '0;
        end
        pending_nxt = ((pending & ~take_mask_c) | new_fault_c) & ~clear_mask;
        status_nxt  = (fault_status | new_fault_c) & ~clear_mask;
        alarm_nxt   = |fault_status;
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) cnt[i] <= '0;
            threshold    <= CNT_W'(THRESH_DEF);
            pending      <= '0;
            fault_status <= '0;
            alarm        <= 1'b0;
            evt_valid    <= 1'b0;
            evt_ch       <= '0;
            scan_ch      <= '0;
        end else begin
            cnt          <= cnt_nxt;
            threshold    <= threshold_nxt;
            pending      <= pending_nxt;
            fault_status <= status_nxt;
            alarm        <= alarm_nxt;
            evt_valid    <= evt_valid_nxt;
            evt_ch       <= evt_ch_nxt;
            scan_ch      <= scan_ch_nxt;
        end
    end

endmodule

// File: tb/tb_fault_monitor_ctrl.sv
// Directed bench for fault_monitor_ctrl: debounce latency, glitch rejection,
// event ordering, clear, config gating and asynchronous reset.
module tb_fault_monitor_ctrl;

    localparam int unsigned NCH  = 4;
    localparam int unsigned CW   = 10;
    localparam int unsigned CH_W = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            enable;
    logic [NCH-1:0]  noisy_in;
    logic            cfg_we;
    logic [CW-1:0]   cfg_threshold;
    logic [NCH-1:0]  clear_mask;
    logic [NCH-1:0]  fault_status;
    logic            alarm;
    logic            evt_valid;
    logic [CH_W-1:0] evt_ch;
    logic            evt_ack;
    logic [CH_W-1:0] scan_ch;

    int checks = 0;
    int errors = 0;
    int mptr   = 0;

    fault_monitor_ctrl #(.NCH(NCH), .CNT_W(CW), .THRESH_DEF(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .noisy_in      (noisy_in),
        .cfg_we        (cfg_we),
        .cfg_threshold (cfg_threshold),
        .clear_mask    (clear_mask),
        .fault_status  (fault_status),
        .alarm         (alarm),
        .evt_valid     (evt_valid),
        .evt_ch        (evt_ch),
        .evt_ack       (evt_ack),
        .scan_ch       (scan_ch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; the bench tracks the scan pointer itself.
    task automatic tick();
        @(posedge clk);
        #1;
        if (enable && !reset) mptr = (mptr + 1) % NCH;
    endtask

    // Advance until the edge that samples channel ch has just happened.
    task automatic visit(input int ch);
        for (int i = 0; i < NCH && mptr != ch; i++) tick();
        tick();
    endtask

    task automatic ack_event();
        evt_ack = 1'b1;
        tick();
        evt_ack = 1'b0;
        chk("ack_drops_valid", 32'(evt_valid), 32'd0);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; noisy_in = '0; cfg_we = 1'b0;
        cfg_threshold = '0; clear_mask = '0; evt_ack = 1'b0;
        #12;
        chk("rst_status", 32'(fault_status), 32'h0);
        chk("rst_alarm",  32'(alarm),        32'h0);
        chk("rst_valid",  32'(evt_valid),    32'h0);
        chk("rst_scan",   32'(scan_ch),      32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        mptr  = 0;

        // Threshold 2, ch1 held high: confirm on the 3rd visit
        enable = 1'b1; noisy_in = 4'b0010;
        visit(1);
        chk("t1_visit1", 32'(fault_status), 32'h0);
        visit(1);
        chk("t1_visit2", 32'(fault_status), 32'h0);
        visit(1);
        chk("t1_visit3_status", 32'(fault_status), 32'h2);
        chk("t1_visit3_valid",  32'(evt_valid),    32'h0);
        chk("t1_visit3_alarm",  32'(alarm),        32'h0);
        tick();
        chk("t1_evt_valid", 32'(evt_valid), 32'h1);
        chk("t1_evt_ch",    32'(evt_ch),    32'h1);
        chk("t1_alarm",     32'(alarm),     32'h1);
        chk("t1_scan",      32'(scan_ch),   32'(mptr));
        ack_event();
        noisy_in = '0; clear_mask = 4'b0010;
        tick();
        clear_mask = '0;
        chk("t1_cleared", 32'(fault_status), 32'h0);
        tick();
        chk("t1_alarm_off", 32'(alarm), 32'h0);

        // Glitch on ch2: H,H,L,H,H must not confirm; a 3rd consecutive H does
        noisy_in[2] = 1'b1; visit(2); visit(2);
        noisy_in[2] = 1'b0; visit(2);
        noisy_in[2] = 1'b1; visit(2); visit(2);
        chk("t2_no_status", 32'(fault_status), 32'h0);
        chk("t2_no_event",  32'(evt_valid),    32'h0);
        visit(2);
        chk("t2_confirm", 32'(fault_status), 32'h4);
        tick();
        chk("t2_evt_ch", 32'(evt_ch), 32'h2);
        ack_event();
        noisy_in = '0; clear_mask = 4'b0100;
        tick();
        clear_mask = '0;

        // Simultaneous faults on ch0 and ch3, ack withheld
        visit(3);
        noisy_in = 4'b1001;
        visit(0); visit(0); visit(0);
        chk("t3_ch0_status", 32'(fault_status), 32'h1);
        tick();
        chk("t3_first_valid", 32'(evt_valid), 32'h1);
        chk("t3_first_ch",    32'(evt_ch),    32'h0);
        visit(3);
        chk("t3_both_status", 32'(fault_status), 32'h9);
        tick();
        chk("t3_hold_valid", 32'(evt_valid), 32'h1);
        chk("t3_hold_ch",    32'(evt_ch),    32'h0);
        ack_event();
        tick();
        chk("t3_second_valid", 32'(evt_valid), 32'h1);
        chk("t3_second_ch",    32'(evt_ch),    32'h3);
        ack_event();
        tick();
        chk("t3_no_third", 32'(evt_valid),    32'h0);
        chk("t3_status",   32'(fault_status), 32'h9);

        // Clear ch0 while its input stays high, then re-confirm
        clear_mask = 4'b0001;
        tick();
        clear_mask = '0;
        chk("t4_clear", 32'(fault_status), 32'h8);
        visit(0); visit(0);
        chk("t4_not_yet", 32'(fault_status), 32'h8);
        visit(0);
        chk("t4_reconfirm", 32'(fault_status), 32'h9);
        tick();
        chk("t4_evt_valid", 32'(evt_valid), 32'h1);
        chk("t4_evt_ch",    32'(evt_ch),    32'h0);
        ack_event();
        // Clear landing on the confirming edge suppresses the event
        clear_mask = 4'b0001;
        tick();
        clear_mask = '0;
        visit(0); visit(0);
        visit(3);
        clear_mask = 4'b0001;
        tick();
        clear_mask = '0;
        chk("t4_clr_vs_conf", 32'(fault_status), 32'h8);
        for (int i = 0; i < 4; i++) tick();
        chk("t4_no_event",  32'(evt_valid),    32'h0);
        chk("t4_still_clr", 32'(fault_status), 32'h8);
        noisy_in = '0; clear_mask = 4'b1111;
        tick();
        clear_mask = '0;
        chk("t4_all_clear", 32'(fault_status), 32'h0);

        // Threshold write ignored while enabled, honoured while disabled
        cfg_we = 1'b1; cfg_threshold = '0;
        tick();
        cfg_we = 1'b0;
        noisy_in = 4'b0100;
        visit(2);
        chk("t5_ignored", 32'(fault_status), 32'h0);
        noisy_in = '0;
        visit(2);
        enable = 1'b0; cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
        tick(); tick();
        chk("t5_frozen_scan", 32'(scan_ch), 32'(mptr));
        enable = 1'b1; noisy_in = 4'b0100;
        visit(2);
        chk("t5_single_hit", 32'(fault_status), 32'h4);
        tick();
        chk("t5_evt_valid", 32'(evt_valid), 32'h1);
        chk("t5_evt_ch",    32'(evt_ch),    32'h2);

        // Asynchronous reset while an event is outstanding
        reset = 1'b1;
        #1;
        chk("t6_status", 32'(fault_status), 32'h0);
        chk("t6_alarm",  32'(alarm),        32'h0);
        chk("t6_valid",  32'(evt_valid),    32'h0);
        chk("t6_evt_ch", 32'(evt_ch),       32'h0);
        chk("t6_scan",   32'(scan_ch),      32'h0);
        enable = 1'b0; noisy_in = '0;
        tick();
        reset = 1'b0;
        mptr  = 0;
        enable = 1'b1; noisy_in = 4'b0010;
        tick();
        chk("t6_no_evt", 32'(evt_valid), 32'h0);
        visit(1); visit(1);
        chk("t6_thresh_default", 32'(fault_status), 32'h0);
        visit(1);
        chk("t6_confirm", 32'(fault_status), 32'h2);
        chk("t6_scan_track", 32'(scan_ch), 32'(mptr));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
